// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, I-cache req/ready handshake, output slot,
// one-entry skid buffer and execute-stage redirects.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    input  logic            stall,
    output logic            icReq,
    output logic [XLEN-1:0] icAddr,
    input  logic            icReady,
    input  logic [31:0]     icData,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instrPC,
    output logic [XLEN-1:0] instrPCPlus4,
    output logic            instrValid,
    output logic            misalign
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] reqAddr_q, reqAddr_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instrPC_q, instrPC_d;
    logic            instrValid_q, instrValid_d;
    logic [31:0]     skidInstr_q, skidInstr_d;
    logic [XLEN-1:0] skidPC_q, skidPC_d;
    logic            skidValid_q, skidValid_d;
    logic            misalign_q, misalign_d;

    logic            slotFree;
    logic            consume;
    logic            miss;
    logic [XLEN-1:0] pcNext;

    assign slotFree = !instrValid_q || !stall;
    assign consume  = instrValid_q && !stall;
    assign miss     = icReq && !icReady;
    assign pcNext   = pc_q + XLEN'(4);

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            reqAddr_q    <= RESET_PC;
            instr_q      <= NOP;
            instrPC_q    <= '0;
            instrValid_q <= 1'b0;
            skidInstr_q  <= NOP;
            skidPC_q     <= '0;
            skidValid_q  <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            reqAddr_q    <= reqAddr_d;
            instr_q      <= instr_d;
            instrPC_q    <= instrPC_d;
            instrValid_q <= instrValid_d;
            skidInstr_q  <= skidInstr_d;
            skidPC_q     <= skidPC_d;
            skidValid_q  <= skidValid_d;
            misalign_q   <= misalign_d;
        end
    end

    // Next state: redirect wins; an unanswered request must be drained
    always_comb begin
        state_d = state_q;
        if (pcSrc) begin
            state_d = miss ? S_DRAIN : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: if (miss) state_d = S_WAIT;
                S_WAIT:  if (icReady) state_d = S_FETCH;
                S_DRAIN: if (icReady) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Cache request outputs; nothing is requested while in reset
    always_comb begin
        icReq  = 1'b0;
        icAddr = reqAddr_q;
        unique case (state_q)
            S_FETCH: begin
                icReq  = !skidValid_q && slotFree;
                icAddr = pc_q;
            end
            S_WAIT:  icReq = 1'b1;
            S_DRAIN: icReq = 1'b1;
            default: icReq = 1'b0;
        endcase
        if (!rst_n) icReq = 1'b0;
    end

    // Datapath: PC, slot and skid updates
    always_comb begin
        pc_d         = pc_q;
        reqAddr_d    = reqAddr_q;
        instr_d      = instr_q;
        instrPC_d    = instrPC_q;
        instrValid_d = instrValid_q && !consume;
        skidInstr_d  = skidInstr_q;
        skidPC_d     = skidPC_q;
        skidValid_d  = skidValid_q;
        misalign_d   = 1'b0;
        if (pcSrc) begin
            pc_d         = {pcTarget[XLEN-1:2], 2'b00};
            instrValid_d = 1'b0;
            skidValid_d  = 1'b0;
            misalign_d   = |pcTarget[1:0];
            if (state_q == S_FETCH && miss) reqAddr_d = pc_q;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (skidValid_q && slotFree) begin
                        instr_d      = skidInstr_q;
                        instrPC_d    = skidPC_q;
                        instrValid_d = 1'b1;
                        skidValid_d  = 1'b0;
                    end else if (icReq && icReady) begin
                        instr_d      = icData;
                        instrPC_d    = pc_q;
                        instrValid_d = 1'b1;
                        pc_d         = pcNext;
                    end else if (miss) begin
                        reqAddr_d = pc_q;
                    end
                end
                S_WAIT: begin
                    if (icReady) begin
                        if (slotFree) begin
                            instr_d      = icData;
                            instrPC_d    = reqAddr_q;
                            instrValid_d = 1'b1;
                        end else begin
                            skidInstr_d = icData;
                            skidPC_d    = reqAddr_q;
                            skidValid_d = 1'b1;
                        end
                        pc_d = pcNext;
                    end
                end
                S_DRAIN: ;
                default: ;
            endcase
        end
    end

    assign instr        = instrValid_q ? instr_q : NOP;
    assign instrPC      = instrPC_q;
    assign instrPCPlus4 = instrPC_q + XLEN'(4);
    assign instrValid   = instrValid_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a scoreboard monitor that
// tracks every accepted fetch address until it is consumed or flushed.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        stall;
    logic        icReq;
    logic [31:0] icAddr;
    logic        icReady;
    logic [31:0] icData;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic [31:0] instrPCPlus4;
    logic        instrValid;
    logic        misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [31:0] nextAddr;
    logic [31:0] exp;
    bit          drain;

    fetch_unit #(
        .XLEN(32), .RESET_PC(RESET_PC), .NOP(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pcSrc(pcSrc), .pcTarget(pcTarget),
        .stall(stall), .icReq(icReq), .icAddr(icAddr), .icReady(icReady),
        .icData(icData), .instr(instr), .instrPC(instrPC),
        .instrPCPlus4(instrPCPlus4), .instrValid(instrValid),
        .misalign(misalign)
    );

    assign icData = ~icAddr;

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) cyc();
        #2;
        checks++; if (icReq !== 1'b0) begin errors++; $display("FAIL rst_icReq: got %b want 0", icReq); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instrValid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        checks++; if (instrPC !== 32'h0 || instrPCPlus4 !== 32'h4) begin errors++; $display("FAIL rst_pc: got %h/%h want 0/4", instrPC, instrPCPlus4); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign); end
    endtask

    task automatic test_hit_stream;
        cyc(); rst_n = 1'b1; #2;
        checks++; if (icReq !== 1'b1 || icAddr !== RESET_PC) begin errors++; $display("FAIL hit_c1_req: got %b %h want 1 %h", icReq, icAddr, RESET_PC); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL hit_c1_valid: got %b want 0", instrValid); end
        cyc(); #2;
        checks++; if (instrValid !== 1'b1 || instrPC !== 32'h0 || instrPCPlus4 !== 32'h4) begin errors++; $display("FAIL hit_c2_out: got %b %h %h want 1 0 4", instrValid, instrPC, instrPCPlus4); end
        checks++; if (instr !== 32'hFFFF_FFFF || icAddr !== 32'h4) begin errors++; $display("FAIL hit_c2_data: got %h %h want ffffffff 4", instr, icAddr); end
        cyc(); #2;
        checks++; if (instrPC !== 32'h4 || instrPCPlus4 !== 32'h8 || icAddr !== 32'h8) begin errors++; $display("FAIL hit_c3: got %h %h %h want 4 8 8", instrPC, instrPCPlus4, icAddr); end
    endtask

    task automatic test_miss;
        icReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            checks++; if (icReq !== 1'b1 || icAddr !== 32'h8) begin errors++; $display("FAIL miss_hold%0d: got %b %h want 1 8", i, icReq, icAddr); end
            checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL miss_valid%0d: got %b want 0", i, instrValid); end
        end
        icReady = 1'b1;
        cyc(); #2;
        checks++; if (instrValid !== 1'b1 || instrPC !== 32'h8 || instr !== ~32'h8) begin errors++; $display("FAIL miss_out: got %b %h %h want 1 8 %h", instrValid, instrPC, instr, ~32'h8); end
        checks++; if (icReq !== 1'b1 || icAddr !== 32'hC) begin errors++; $display("FAIL miss_next: got %b %h want 1 c", icReq, icAddr); end
    endtask

    task automatic test_stall;
        cyc(); #2;
        checks++; if (instrPC !== 32'hC || icAddr !== 32'h10) begin errors++; $display("FAIL stall_pre: got %h %h want c 10", instrPC, icAddr); end
        icReady = 1'b0;
        cyc(); #2;
        checks++; if (instrValid !== 1'b0 || icReq !== 1'b1 || icAddr !== 32'h10) begin errors++; $display("FAIL stall_wait: got %b %b %h want 0 1 10", instrValid, icReq, icAddr); end
        stall = 1'b1; icReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #2;
            checks++; if (instrValid !== 1'b1 || instrPC !== 32'h10) begin errors++; $display("FAIL stall_hold%0d: got %b %h want 1 10", i, instrValid, instrPC); end
            checks++; if (icReq !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d: got %b want 0", i, icReq); end
        end
        stall = 1'b0;
        cyc(); #2;
        checks++; if (instrValid !== 1'b1 || instrPC !== 32'h14 || icAddr !== 32'h18) begin errors++; $display("FAIL stall_rel: got %b %h %h want 1 14 18", instrValid, instrPC, icAddr); end
    endtask

    task automatic test_redirect_miss;
        for (int i = 0; i < 8; i++) begin
            if (icAddr == 32'h20) break;
            cyc(); #2;
        end
        checks++; if (icAddr !== 32'h20) begin errors++; $display("FAIL redir_reach: got %h want 20", icAddr); end
        icReady = 1'b0;
        cyc(); #2;
        checks++; if (icReq !== 1'b1 || icAddr !== 32'h20 || instrValid !== 1'b0) begin errors++; $display("FAIL redir_wait: got %b %h %b want 1 20 0", icReq, icAddr, instrValid); end
        pcSrc = 1'b1; pcTarget = 32'h100;
        for (int i = 0; i < 2; i++) begin
            cyc(); pcSrc = 1'b0; #2;
            checks++; if (icReq !== 1'b1 || icAddr !== 32'h20) begin errors++; $display("FAIL redir_drain%0d: got %b %h want 1 20", i, icReq, icAddr); end
            checks++; if (instrValid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL redir_flush%0d: got %b %b want 0 0", i, instrValid, misalign); end
        end
        icReady = 1'b1;
        cyc(); #2;
        checks++; if (icReq !== 1'b1 || icAddr !== 32'h100 || instrValid !== 1'b0) begin errors++; $display("FAIL redir_target: got %b %h %b want 1 100 0", icReq, icAddr, instrValid); end
        cyc(); #2;
        checks++; if (instrValid !== 1'b1 || instrPC !== 32'h100 || instr !== ~32'h100) begin errors++; $display("FAIL redir_out: got %b %h %h want 1 100", instrValid, instrPC, instr); end
    endtask

    task automatic test_misalign;
        pcSrc = 1'b1; pcTarget = 32'h102;
        cyc(); pcSrc = 1'b0; #2;
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misalign); end
        checks++; if (icAddr !== 32'h100 || instrValid !== 1'b0) begin errors++; $display("FAIL mis_addr: got %h %b want 100 0", icAddr, instrValid); end
        cyc(); #2;
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misalign); end
        checks++; if (instrValid !== 1'b1 || instrPC !== 32'h100) begin errors++; $display("FAIL mis_out: got %b %h want 1 100", instrValid, instrPC); end
    endtask

    task automatic test_reset_mid_miss;
        pcSrc = 1'b1; pcTarget = 32'h40;
        cyc(); pcSrc = 1'b0; icReady = 1'b0; #2;
        checks++; if (icReq !== 1'b1 || icAddr !== 32'h40) begin errors++; $display("FAIL rmm_req: got %b %h want 1 40", icReq, icAddr); end
        cyc(); #2;
        checks++; if (icReq !== 1'b1 || icAddr !== 32'h40 || instrValid !== 1'b0) begin errors++; $display("FAIL rmm_wait: got %b %h %b want 1 40 0", icReq, icAddr, instrValid); end
        cyc(); rst_n = 1'b0; #2;
        checks++; if (icReq !== 1'b0 || instrValid !== 1'b0) begin errors++; $display("FAIL rmm_low: got %b %b want 0 0", icReq, instrValid); end
        cyc(); rst_n = 1'b1; icReady = 1'b1; #2;
        checks++; if (icReq !== 1'b1 || icAddr !== RESET_PC || instrValid !== 1'b0) begin errors++; $display("FAIL rmm_restart: got %b %h %b want 1 %h 0", icReq, icAddr, instrValid, RESET_PC); end
        cyc(); #2;
        checks++; if (instrValid !== 1'b1 || instrPC !== RESET_PC) begin errors++; $display("FAIL rmm_out: got %b %h want 1 %h", instrValid, instrPC, RESET_PC); end
    endtask

    task automatic test_wrap;
        pcSrc = 1'b1; pcTarget = 32'hFFFF_FFFC;
        cyc(); pcSrc = 1'b0; #2;
        checks++; if (icAddr !== 32'hFFFF_FFFC || misalign !== 1'b0) begin errors++; $display("FAIL wrap_req: got %h %b want fffffffc 0", icAddr, misalign); end
        cyc(); #2;
        checks++; if (instrPC !== 32'hFFFF_FFFC || instrPCPlus4 !== 32'h0 || icAddr !== 32'h0) begin errors++; $display("FAIL wrap_top: got %h %h %h want fffffffc 0 0", instrPC, instrPCPlus4, icAddr); end
        cyc(); #2;
        checks++; if (instrValid !== 1'b1 || instrPC !== 32'h0 || instrPCPlus4 !== 32'h4) begin errors++; $display("FAIL wrap_zero: got %b %h %h want 1 0 4", instrValid, instrPC, instrPCPlus4); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 400; i++) begin
            cyc();
            stall    = ($urandom_range(0, 3) == 0);
            icReady  = ($urandom_range(0, 2) != 0);
            pcSrc    = ($urandom_range(0, 15) == 0);
            pcTarget = 32'($urandom_range(0, 1023));
        end
        cyc();
        stall = 1'b0; icReady = 1'b0; pcSrc = 1'b0;
        repeat (3) cyc();
        #2;
        checks++; if (q.size() != 0 || instrValid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %0d pending valid=%b want 0 0", q.size(), instrValid); end
        icReady = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pcSrc = 1'b0; pcTarget = '0;
        stall = 1'b0; icReady = 1'b1;
        nextAddr = RESET_PC; drain = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete(); nextAddr = RESET_PC; drain = 1'b0;
                end else if (pcSrc) begin
                    q.delete();
                    nextAddr = {pcTarget[31:2], 2'b00};
                    drain = icReq && !icReady;
                end else if (drain) begin
                    if (icReady) drain = 1'b0;
                end else begin
                    if (instrValid && !stall) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++; $display("FAIL sb_extra: got PC %h want none", instrPC);
                        end else begin
                            exp = q.pop_front();
                            if (instrPC !== exp || instr !== ~exp || instrPCPlus4 !== exp + 32'd4) begin
                                errors++; $display("FAIL sb_out: got %h %h %h want %h %h %h", instrPC, instr, instrPCPlus4, exp, ~exp, exp + 32'd4);
                            end
                        end
                    end
                    if (icReq) begin
                        checks++;
                        if (icAddr !== nextAddr) begin
                            errors++; $display("FAIL sb_addr: got %h want %h", icAddr, nextAddr);
                        end
                        if (icReady) begin
                            q.push_back(nextAddr);
                            nextAddr = nextAddr + 32'd4;
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_hit_stream();
        test_miss();
        test_stall();
        test_redirect_miss();
        test_misalign();
        test_reset_mid_miss();
        test_wrap();
        test_back_to_back();
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
